vga_ram_buffer: RTL

Double-buffered 320x240x12-bit frame store between the masking pipeline and `vga_controller`. A valid/ready pixel stream fills the back bank in raster order. `vga_controller` reads the front bank by row/column address. Banks swap only at the start of a VGA vertical sync pulse after a complete frame, so the display never shows a partially written frame.

---
 rtl/vga_ram_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/vga_ram_buffer.sv
// vga_ram_buffer: double-buffered IMG_W x IMG_H frame store; in_* stream fills back bank, row_read/col_read -> ram_pixel reads front bank, vga_vs fall swaps banks (frame_done), in_sof mid-frame restarts (sync_err)
module vga_ram_buffer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic [7:0]       row_read,
  input  logic [8:0]       col_read,
  output logic [PIX_W-1:0] ram_pixel,
  input  logic             vga_vs,
  output logic             frame_done,
  output logic             sync_err
);
  localparam int N = IMG_W * IMG_H;
  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;
  state_t r_state;
  logic r_front, r_fall, r_frame_done, r_sync_err;
  logic [2:0] r_vs;
  logic [16:0] r_wr_addr;
  logic [7:0] r_wr_row;
  logic [8:0] r_wr_col;
  logic [PIX_W-1:0] r_ram_pixel;
  logic [PIX_W-1:0] r_mem0 [N];
  logic [PIX_W-1:0] r_mem1 [N];
  logic w_acc, w_we, w_last, w_col_wrap, w_swap, w_front_nx, w_oor;
  logic [16:0] w_wa, w_ra;
  assign in_ready = ~rst & (r_state != WAIT_SWAP);
  assign w_acc = in_valid & in_ready;
  assign w_we = w_acc & (in_sof | (r_state == WRITE));
  assign w_wa = in_sof ? '0 : r_wr_addr;
  assign w_col_wrap = r_wr_col == 9'(IMG_W - 1);
  assign w_last = w_col_wrap & (r_wr_row == 8'(IMG_H - 1));
  assign w_swap = (r_state == WAIT_SWAP) & r_fall;
  assign w_front_nx = r_front ^ w_swap;
  assign w_ra = {1'b0, row_read, 8'd0} + {3'd0, row_read, 6'd0} + {8'd0, col_read};
  assign w_oor = (col_read >= 9'(IMG_W)) | (row_read >= 8'(IMG_H));
  assign ram_pixel = r_ram_pixel;
  assign frame_done = r_frame_done;
  assign sync_err = r_sync_err;
  always_ff @(posedge clk) begin
    if (w_we && r_front) r_mem0[w_wa] <= in_pixel;
    if (w_we && !r_front) r_mem1[w_wa] <= in_pixel;
  end
  always_ff @(posedge clk) begin
    if (rst) r_ram_pixel <= '0;
    else r_ram_pixel <= w_oor ? '0 : (w_front_nx ? r_mem1[w_ra] : r_mem0[w_ra]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_front <= 1'b0;
      r_wr_addr <= '0;
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_vs <= '1;
      r_fall <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_vs <= {r_vs[1:0], vga_vs};
      r_fall <= r_vs[2] & ~r_vs[1] & (r_state == WAIT_SWAP);
      r_frame_done <= w_swap;
      r_sync_err <= w_acc & in_sof & (r_state == WRITE);
      r_front <= w_front_nx;
      if (w_acc && in_sof) begin
        r_wr_addr <= 17'd1;
        r_wr_col <= 9'd1;
        r_wr_row <= '0;
        r_state <= WRITE;
      end else if (w_acc && r_state == WRITE) begin
        r_wr_addr <= r_wr_addr + 17'd1;
        r_wr_col <= w_col_wrap ? '0 : r_wr_col + 9'd1;
        r_wr_row <= r_wr_row + 8'(w_col_wrap);
        r_state <= w_last ? WAIT_SWAP : WRITE;
      end else if (r_state == WAIT_SWAP && r_frame_done) r_state <= IDLE;
    end
  end
endmodule
